// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_stage_if
// Purpose : data-memory request/acknowledge bus between the MEM stage and memory
// Revision: 1.0
// ============================================================================
interface mem_access_stage_if #(
  parameter int XLEN = 64
);
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wmask;
  logic              ack;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, wdata, wmask, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wmask, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_stage
// Purpose : MEM pipeline stage - data-memory access, stall control, MEM/WB regs
// Revision: 1.0
// ============================================================================
module mem_access_stage #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  wire logic            clock,
  input  wire logic            reset,
  input  wire logic            ex_valid,
  input  wire logic [XLEN-1:0] ex_alu_result,
  input  wire logic [XLEN-1:0] ex_rs2_data,
  input  wire logic            ex_mem_read,
  input  wire logic            ex_mem_write,
  input  wire logic [1:0]      ex_mem_size,
  input  wire logic            ex_mem_ext_un,
  input  wire logic            ex_csr_rena,
  input  wire logic [XLEN-1:0] ex_csr_data,
  input  wire logic [4:0]      ex_rd_waddr,
  input  wire logic            ex_rd_wena,
  mem_access_stage_if.master   mem,
  output logic                 mem_stall,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      wb_alu_result,
  output logic [XLEN-1:0]      wb_mem_data,
  output logic [7:0]           wb_byte_enable,
  output logic                 wb_mem_to_reg,
  output logic                 wb_mem_ext_un,
  output logic                 wb_csr_rena,
  output logic [XLEN-1:0]      wb_csr_data,
  output logic [4:0]           wb_rd_waddr,
  output logic                 wb_rd_wena,
  output logic                 exc_misalign,
  output logic                 exc_bus_err
);

  localparam logic [0:0] c_idle    = 1'b0;
  localparam logic [0:0] c_busy    = 1'b1;
  localparam logic [7:0] c_timeout = TIMEOUT[7:0];

  logic [0:0]      r_state, w_next_state;
  logic [7:0]      r_wait_cnt;
  logic            w_memop, w_aligned, w_timeout;
  logic [7:0]      w_size_mask;

  // latched bus request and the instruction metadata parked while BUSY
  logic            r_req_we;
  logic [XLEN-1:0] r_req_addr, r_req_wdata;
  logic [7:0]      r_req_wmask;
  logic [XLEN-1:0] r_p_alu, r_p_csr_data;
  logic            r_p_read, r_p_ext_un, r_p_csr_rena, r_p_rd_wena;
  logic [7:0]      r_p_mask;
  logic [4:0]      r_p_rd_waddr;

  assign w_memop = ex_valid & (ex_mem_read | ex_mem_write);

  always_comb begin
    w_aligned   = 1'b1;
    w_size_mask = 8'h01;
    case (ex_mem_size)
      2'd0: begin w_aligned = 1'b1;                        w_size_mask = 8'h01; end
      2'd1: begin w_aligned = (ex_alu_result[0] == 1'b0);   w_size_mask = 8'h03; end
      2'd2: begin w_aligned = (ex_alu_result[1:0] == 2'b0); w_size_mask = 8'h0F; end
      default: begin w_aligned = (ex_alu_result[2:0] == 3'b0); w_size_mask = 8'hFF; end
    endcase
  end

  assign w_timeout = (r_state == c_busy) & ~mem.ack & (r_wait_cnt == c_timeout);

  // state register and wait counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= c_idle;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= (r_state == c_busy && w_next_state == c_busy) ? r_wait_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (w_memop & w_aligned) w_next_state = c_busy;
      default: if (mem.ack | w_timeout) w_next_state = c_idle;
    endcase
  end

  always_comb begin
    mem.req   = (r_state == c_busy);
    mem.we    = r_req_we;
    mem.addr  = r_req_addr;
    mem.wdata = r_req_wdata;
    mem.wmask = r_req_wmask;
    if (r_state == c_idle) mem_stall = w_memop & w_aligned;
    else                   mem_stall = ~mem.ack & ~w_timeout;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_we <= 1'b0; r_req_addr <= '0; r_req_wdata <= '0; r_req_wmask <= 8'h00;
      r_p_alu <= '0; r_p_csr_data <= '0; r_p_read <= 1'b0; r_p_ext_un <= 1'b0;
      r_p_csr_rena <= 1'b0; r_p_rd_wena <= 1'b0; r_p_mask <= 8'h00; r_p_rd_waddr <= 5'd0;
      wb_valid <= 1'b0; wb_alu_result <= '0; wb_mem_data <= '0; wb_byte_enable <= 8'h00;
      wb_mem_to_reg <= 1'b0; wb_mem_ext_un <= 1'b0; wb_csr_rena <= 1'b0; wb_csr_data <= '0;
      wb_rd_waddr <= 5'd0; wb_rd_wena <= 1'b0; exc_misalign <= 1'b0; exc_bus_err <= 1'b0;
    end else if (r_state == c_idle) begin
      exc_bus_err <= 1'b0;
      if (w_memop & w_aligned) begin
        r_req_we     <= ex_mem_write;
        r_req_addr   <= {ex_alu_result[XLEN-1:3], 3'b000};
        r_req_wdata  <= ex_rs2_data << {ex_alu_result[2:0], 3'b000};
        r_req_wmask  <= w_size_mask << ex_alu_result[2:0];
        r_p_alu      <= ex_alu_result;
        r_p_csr_data <= ex_csr_data;
        r_p_read     <= ex_mem_read;
        r_p_ext_un   <= ex_mem_ext_un;
        r_p_csr_rena <= ex_csr_rena;
        r_p_rd_wena  <= ex_rd_wena;
        r_p_mask     <= w_size_mask;
        r_p_rd_waddr <= ex_rd_waddr;
        wb_valid     <= 1'b0;
        exc_misalign <= 1'b0;
      end else begin
        wb_valid       <= ex_valid;
        wb_alu_result  <= ex_alu_result;
        wb_mem_data    <= '0;
        wb_byte_enable <= ex_mem_read ? w_size_mask : 8'h00;
        wb_mem_to_reg  <= ex_mem_read;
        wb_mem_ext_un  <= ex_mem_ext_un;
        wb_csr_rena    <= ex_csr_rena;
        wb_csr_data    <= ex_csr_data;
        wb_rd_waddr    <= ex_rd_waddr;
        wb_rd_wena     <= ex_rd_wena & ~w_memop;
        exc_misalign   <= w_memop;
      end
    end else if (mem.ack | w_timeout) begin
      // a completed or aborted transaction retires the parked instruction
      wb_valid       <= 1'b1;
      wb_alu_result  <= r_p_alu;
      wb_mem_data    <= (mem.ack & r_p_read) ? mem.rdata : '0;
      wb_byte_enable <= r_p_read ? r_p_mask : 8'h00;
      wb_mem_to_reg  <= r_p_read;
      wb_mem_ext_un  <= r_p_ext_un;
      wb_csr_rena    <= r_p_csr_rena;
      wb_csr_data    <= r_p_csr_data;
      wb_rd_waddr    <= r_p_rd_waddr;
      wb_rd_wena     <= r_p_rd_wena & mem.ack;
      exc_misalign   <= 1'b0;
      exc_bus_err    <= ~mem.ack;
    end else begin
      wb_valid     <= 1'b0;
      exc_misalign <= 1'b0;
      exc_bus_err  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_stage
// Purpose : directed self-checking bench for mem_access_stage
// Revision: 1.0
// ============================================================================
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_ext_un, ex_csr_rena, ex_rd_wena;
  logic [63:0] ex_alu_result, ex_rs2_data, ex_csr_data;
  logic [1:0]  ex_mem_size;
  logic [4:0]  ex_rd_waddr;
  logic        mem_stall, wb_valid, wb_mem_to_reg, wb_mem_ext_un, wb_csr_rena, wb_rd_wena;
  logic        exc_misalign, exc_bus_err;
  logic [63:0] wb_alu_result, wb_mem_data, wb_csr_data;
  logic [7:0]  wb_byte_enable;
  logic [4:0]  wb_rd_waddr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_access_stage_if #(.XLEN(64)) bus ();

  mem_access_stage #(.XLEN(64), .TIMEOUT(255)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_ext_un(ex_mem_ext_un), .ex_csr_rena(ex_csr_rena), .ex_csr_data(ex_csr_data),
    .ex_rd_waddr(ex_rd_waddr), .ex_rd_wena(ex_rd_wena),
    .mem(bus),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
    .wb_mem_data(wb_mem_data), .wb_byte_enable(wb_byte_enable), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_mem_ext_un(wb_mem_ext_un), .wb_csr_rena(wb_csr_rena), .wb_csr_data(wb_csr_data),
    .wb_rd_waddr(wb_rd_waddr), .wb_rd_wena(wb_rd_wena),
    .exc_misalign(exc_misalign), .exc_bus_err(exc_bus_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // outputs are sampled 2 time units after the rising edge
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_size = 2'd0; ex_mem_ext_un = 0;
    ex_csr_rena = 0; ex_csr_data = '0; ex_rd_wena = 0; ex_rd_waddr = 5'd0;
    ex_alu_result = '0; ex_rs2_data = '0;
  endtask

  task automatic ex_mem(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [63:0] addr, input logic [63:0] rs2, input logic [4:0] rdw);
    ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_mem_size = sz;
    ex_alu_result = addr; ex_rs2_data = rs2; ex_rd_waddr = rdw; ex_rd_wena = rd;
    #1;
  endtask

  initial begin
    int n;
    reset = 1; bus.ack = 0; bus.rdata = '0;
    ex_idle();
    step(); step();
    reset = 0;
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_req", bus.req, 0);
    chk("rst_mem_addr", bus.addr, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    chk("rst_exc", {exc_misalign, exc_bus_err}, 0);

    // LB, ack after one BUSY cycle
    ex_mem(1, 0, 2'd0, 64'h8000_1003, 64'h0, 5'd3);
    chk("lb_stall_accept", mem_stall, 1);
    step();
    chk("lb_req", bus.req, 1);
    chk("lb_addr", bus.addr, 64'h8000_1000);
    chk("lb_wmask", bus.wmask, 8'h08);
    chk("lb_we", bus.we, 0);
    chk("lb_wb_valid_busy", wb_valid, 0);
    bus.ack = 1; bus.rdata = 64'h1122_3344_8566_7788;
    #1;
    chk("lb_stall_on_ack", mem_stall, 0);
    step();
    bus.ack = 0; bus.rdata = '0; ex_idle();
    #1;
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_data", wb_mem_data, 64'h1122_3344_8566_7788);
    chk("lb_wb_be", wb_byte_enable, 8'h01);
    chk("lb_wb_to_reg", wb_mem_to_reg, 1);
    chk("lb_wb_alu", wb_alu_result, 64'h8000_1003);
    chk("lb_wb_rd", {wb_rd_wena, wb_rd_waddr}, {1'b1, 5'd3});
    chk("lb_req_drop", bus.req, 0);

    // SW
    ex_mem(0, 1, 2'd2, 64'h8000_2004, 64'hDEAD_BEEF, 5'd0);
    step();
    chk("sw_we", bus.we, 1);
    chk("sw_wmask", bus.wmask, 8'hF0);
    chk("sw_wdata", bus.wdata, 64'hDEAD_BEEF_0000_0000);
    chk("sw_addr", bus.addr, 64'h8000_2000);
    bus.ack = 1; bus.rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.ack = 0; ex_idle();
    #1;
    chk("sw_wb_valid", wb_valid, 1);
    chk("sw_wb_to_reg", wb_mem_to_reg, 0);
    chk("sw_wb_data", wb_mem_data, 0);
    chk("sw_wb_be", wb_byte_enable, 0);

    // LD, ack at cycle 4: stall for cycles 0..3
    ex_mem(1, 0, 2'd3, 64'h8000_3008, 64'h0, 5'd10);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (mem_stall) n++;
      if (c > 0) begin
        chk("ld_req_hold", bus.req, 1);
        chk("ld_addr_hold", bus.addr, 64'h8000_3008);
        chk("ld_no_wb", wb_valid, 0);
      end
      step();
    end
    bus.ack = 1; bus.rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("ld_stall_cycles", n, 4);
    chk("ld_stall_released", mem_stall, 0);
    step();
    bus.ack = 0; ex_idle();
    #1;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_mem_data, 64'h0123_4567_89AB_CDEF);
    chk("ld_wb_be", wb_byte_enable, 8'hFF);
    step();
    chk("ld_wb_once", wb_valid, 0);

    // misaligned LW
    ex_mem(1, 0, 2'd2, 64'h0000_0002, 64'h0, 5'd7);
    chk("mis_no_stall", mem_stall, 0);
    step();
    ex_idle();
    #1;
    chk("mis_no_req", bus.req, 0);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_exc", exc_misalign, 1);
    chk("mis_rd_wena", wb_rd_wena, 0);
    step();
    chk("mis_exc_pulse", exc_misalign, 0);

    // ADD passthrough, then LH that times out
    ex_valid = 1; ex_alu_result = 64'h42; ex_rd_waddr = 5'd5; ex_rd_wena = 1;
    #1;
    chk("add_no_stall", mem_stall, 0);
    step();
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_alu", wb_alu_result, 64'h42);
    chk("add_wb_rd", {wb_rd_wena, wb_rd_waddr}, {1'b1, 5'd5});
    chk("add_wb_be", wb_byte_enable, 0);
    ex_mem(1, 0, 2'd1, 64'h8000_4002, 64'h0, 5'd9);
    step();
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!mem_stall) break;
      step();
      n++;
    end
    chk("to_stall_cycles", n, 255);
    chk("to_req_last", bus.req, 1);
    step();
    ex_idle();
    #1;
    chk("to_wb_valid", wb_valid, 1);
    chk("to_bus_err", exc_bus_err, 1);
    chk("to_rd_wena", wb_rd_wena, 0);
    chk("to_req_drop", bus.req, 0);
    chk("to_stall", mem_stall, 0);
    bus.ack = 1; bus.rdata = 64'h5555;
    step();
    bus.ack = 0;
    #1;
    chk("stray_ack_wb", wb_valid, 0);
    chk("stray_ack_exc", exc_bus_err, 0);
    chk("stray_ack_req", bus.req, 0);

    // reset in the middle of a transaction
    ex_mem(1, 0, 2'd3, 64'h8000_5000, 64'h0, 5'd12);
    step();
    chk("rb_req", bus.req, 1);
    reset = 1;
    step();
    reset = 0; ex_idle();
    #1;
    chk("rb_req_drop", bus.req, 0);
    chk("rb_wb_valid", wb_valid, 0);
    chk("rb_wb_alu", wb_alu_result, 0);
    chk("rb_wb_rd", {wb_rd_wena, wb_rd_waddr}, 0);
    chk("rb_exc", {exc_misalign, exc_bus_err}, 0);
    bus.ack = 1; bus.rdata = 64'hAAAA;
    step();
    bus.ack = 0;
    #1;
    chk("rb_late_ack_wb", wb_valid, 0);
    chk("rb_late_ack_data", wb_mem_data, 0);
    chk("rb_late_ack_req", bus.req, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
